frv_mem_arbiter: RTL
====================

Name: frv_mem_arbiter

Overview:
- Shares one single-port memory bus between the core's instruction fetch port (imem_*) and load/store port (dmem_*).
- Sits between frv_core and a unified SRAM/BRAM, for low-area builds with no separate instruction memory.
- Arbitrates per request and holds a grant while the downstream memory stalls.
- Steers each response back to the requester that issued the request.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive dmem grants while imem waits; the next grant then goes to imem. Legal range 1..15.

Ports:
- g_clk  input  1  global clock
- g_resetn  input  1  reset; one clock; reset is asynchronous and active-low
- imem_cen / dmem_cen  input  1  requester chip enable
- imem_wen / dmem_wen  input  1  requester write enable
- imem_strb / dmem_strb  input  4  requester write strobe
- imem_addr / dmem_addr  input  32  requester address
- imem_wdata / dmem_wdata  input  32  requester write data
- imem_stall / dmem_stall  output  1  stall back to requester
- imem_error / dmem_error  output  1  response error to requester
- imem_rdata / dmem_rdata  output  32  response read data to requester
- mem_cen  output  1  shared bus chip enable
- mem_wen  output  1  shared bus write enable
- mem_strb  output  4  shared bus write strobe
- mem_addr  output  32  shared bus address
- mem_wdata  output  32  shared bus write data
- mem_stall  input  1  shared bus stall
- mem_error  input  1  shared bus error, valid the cycle after acceptance
- mem_rdata  input  32  shared bus read data, valid the cycle after acceptance

Behaviour:
- Protocol:
  - A request is accepted in a cycle with cen=1 and stall=0.
  - The response (rdata/error) is valid exactly one cycle after acceptance.
  - Requesters hold all request signals stable while stalled.
- Registers, all cleared asynchronously when g_resetn=0:
  - lock=0, lock_sel=0
  - resp_vld=0, resp_sel=0
  - starve_cnt=0
  - rr_last=0 (0=imem, 1=dmem)
- While g_resetn=0:
  - mem_cen=0
  - imem_stall=dmem_stall=1
  - imem_error=dmem_error=0
- Grant selection (combinational, used when lock=0):
  - Only one requester active: that requester wins.
  - Both active: dmem wins unless starve_cnt==STARVE_LIMIT, in which case imem wins.
- Lock:
  - If the granted request sees mem_stall=1: set lock=1 and lock_sel=winner.
  - While lock=1, the grant is forced to lock_sel regardless of other requests.
  - lock clears in the cycle the locked request is accepted.
- Mux: mem_cen/wen/strb/addr/wdata are driven from the granted requester. mem_cen=0 when neither requester is active.
- Stalls:
  - Granted requester sees mem_stall.
  - Non-granted active requester sees stall=1.
  - Idle requester sees stall=0.
- Response routing:
  - On acceptance: resp_vld<=1 and resp_sel<=granted port. Otherwise resp_vld<=0.
  - imem_rdata and dmem_rdata are both driven with mem_rdata unconditionally.
  - X_error = mem_error & resp_vld & (resp_sel==X).
- Starvation counter:
  - Increments on a dmem acceptance while imem_cen=1, saturating at STARVE_LIMIT.
  - Clears on any imem acceptance, or in any cycle with imem_cen=0.
- Latency: zero added cycles on the request path for an uncontended request. Throughput is one acceptance per cycle.
- Back-to-back: a new request may be accepted in the same cycle as the previous response is returned.
- Reset mid-operation: in-flight lock and response are discarded; no error or data is routed after reset.

Optional Feature:
- Macro FRV_MEMARB_ROUND_ROBIN_EN.
- Defined:
  - Contention resolves to the port opposite rr_last.
  - rr_last updates on every acceptance.
  - starve_cnt and STARVE_LIMIT are unused and removed.
- Undefined: dmem-priority scheme with the starvation counter, as specified above.
- Lock and response routing are identical in both builds.

Test Plan:
- Uncontended fetch: imem_cen=1, addr=0x80000000, mem_stall=0 → mem_addr=0x80000000 same cycle; next cycle imem_rdata=mem_rdata=0x00000013; imem_error=0.
- Contention, default build: both cen=1, dmem_addr=0x80001000 → dmem granted, imem_stall=1. After 4 consecutive dmem grants, the 5th cycle grants imem; starve_cnt returns to 0.
- Stall lock: imem granted with mem_stall=1 for 3 cycles, dmem_cen raised in cycle 2 → mem_addr holds the imem address throughout; dmem_stall=1 until the imem acceptance.
- Error routing: dmem write accepted, mem_error=1 next cycle → dmem_error=1 and imem_error=0 for exactly one cycle.
- Reset mid-request: g_resetn dropped during a locked stall → mem_cen=0 immediately; after release, lock=0 and no response is routed.
- ROUND_ROBIN_EN build: continuous requests on both ports → grants alternate dmem, imem, dmem, imem starting from reset (rr_last=0).

Source files
------------

// File: rtl/frv_mem_arbiter_if.sv
// frv_mem_arbiter_if: one memory request/response port.
// master drives cen/wen/strb/addr/wdata; slave returns stall/error/rdata.
interface frv_mem_arbiter_if;
  logic        cen;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        error;
  logic [31:0] rdata;

  modport master (
    output cen, wen, strb, addr, wdata,
    input  stall, error, rdata
  );

  modport slave (
    input  cen, wen, strb, addr, wdata,
    output stall, error, rdata
  );
endinterface

// File: rtl/frv_mem_arbiter.sv
// frv_mem_arbiter: shares one memory bus between imem and dmem ports.
// Ports: g_clk, g_resetn, imem/dmem (slave), mem (master).
// Optional FRV_MEMARB_ROUND_ROBIN_EN: round-robin instead of dmem priority.
module frv_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  frv_mem_arbiter_if.slave  imem,
  frv_mem_arbiter_if.slave  dmem,
  frv_mem_arbiter_if.master mem
);

  // lock and lock_sel folded into one encoded state
  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   resp_vld_q;
  logic   resp_sel_q;

  logic act_i;
  logic act_d;
  logic lock;
  logic lock_sel;
  logic pick_d;
  logic gsel;
  logic gnt_vld;
  logic gnt_i;
  logic gnt_d;
  logic accept;

  assign act_i    = imem.cen;
  assign act_d    = dmem.cen;
  assign lock     = (state_q != ST_FREE);
  assign lock_sel = (state_q == ST_LOCK_D);

`ifdef FRV_MEMARB_ROUND_ROBIN_EN
  logic rr_last_q;

  assign pick_d = ~rr_last_q;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rr_last_q <= 1'b0;
    end else if (accept) begin
      rr_last_q <= gsel;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q;
  logic [3:0] starve_d;

  assign pick_d = (starve_q != LIMIT);

  always_comb begin
    starve_d = starve_q;
    if (!act_i) begin
      starve_d = 4'd0;
    end else if (accept && !gsel) begin
      starve_d = 4'd0;
    end else if (accept && gsel && (starve_q != LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // gsel: 0=imem, 1=dmem
  always_comb begin
    gsel    = 1'b0;
    gnt_vld = 1'b0;
    unique case (1'b1)
      lock: begin
        gsel    = lock_sel;
        gnt_vld = lock_sel ? act_d : act_i;
      end
      (!lock && act_i && act_d): begin
        gsel    = pick_d;
        gnt_vld = 1'b1;
      end
      (!lock && act_d && !act_i): begin
        gsel    = 1'b1;
        gnt_vld = 1'b1;
      end
      (!lock && act_i && !act_d): begin
        gsel    = 1'b0;
        gnt_vld = 1'b1;
      end
      default: begin
        gsel    = 1'b0;
        gnt_vld = 1'b0;
      end
    endcase
  end

  assign gnt_i  = gnt_vld & ~gsel;
  assign gnt_d  = gnt_vld & gsel;
  assign accept = g_resetn & gnt_vld & ~mem.stall;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q    <= ST_FREE;
      resp_vld_q <= 1'b0;
      resp_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_vld_q <= accept;
      if (accept) begin
        resp_sel_q <= gsel;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = ST_FREE;
    end else if (gnt_vld && mem.stall) begin
      state_d = gsel ? ST_LOCK_D : ST_LOCK_I;
    end
  end

  always_comb begin
    mem.cen    = g_resetn & gnt_vld;
    mem.wen    = gsel ? dmem.wen   : imem.wen;
    mem.strb   = gsel ? dmem.strb  : imem.strb;
    mem.addr   = gsel ? dmem.addr  : imem.addr;
    mem.wdata  = gsel ? dmem.wdata : imem.wdata;
    imem.stall = ~g_resetn | (act_i & (~gnt_i | mem.stall));
    dmem.stall = ~g_resetn | (act_d & (~gnt_d | mem.stall));
    imem.error = mem.error & resp_vld_q & ~resp_sel_q;
    dmem.error = mem.error & resp_vld_q & resp_sel_q;
    imem.rdata = mem.rdata;
    dmem.rdata = mem.rdata;
  end

endmodule
